// File: rtl/seg7_trace_scan.sv
// Fetch-pair display: shows {PC, Instruction} as four hex digits on a
// multiplexed common-anode 7-segment display (PC hi, PC lo, instr hi, instr lo).
// Latency: outputs registered, one clock after the idx/cap state they reflect.
// Backpressure: none; the scan free-runs and Hold only freezes the capture register.
// Optional feature: SEG7_DP_BLINK_EN blinks the separator point every 32 scans.
module seg7_trace_scan #(
   parameter int PRESCALE_W = 16
) (
   input  logic       Clk_O,
   input  logic       Reset,
   input  logic [7:0] PC,
   input  logic [7:0] Instruction,
   input  logic       Capture,
   input  logic       Hold,
   output logic [6:0] Seg,
   output logic       Dp,
   output logic [3:0] An
);

   logic [PRESCALE_W-1:0] r_pre;
   logic [1:0]            r_idx;
   logic [15:0]           r_cap;

   logic                  w_pre_wrap;
   logic [3:0]            w_nib;
   logic [3:0]            w_an;
   logic [6:0]            w_seg;
   logic                  w_dp_lit;

   assign w_pre_wrap = &r_pre;

   // Refresh prescaler and digit index: idx steps once per full prescaler period.
   always_ff @(posedge Clk_O or negedge Reset) begin
      if (!Reset) begin
         r_pre <= '0;
         r_idx <= 2'd0;
      end else begin
         r_pre <= r_pre + PRESCALE_W'(1);
         if (w_pre_wrap) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // Capture register: Hold has priority so a frozen value survives Capture pulses.
   always_ff @(posedge Clk_O or negedge Reset) begin
      if (!Reset) begin
         r_cap <= 16'h0000;
      end else if (Capture && !Hold) begin
         r_cap <= {PC, Instruction};
      end
   end

`ifdef SEG7_DP_BLINK_EN
   logic [5:0] r_rnd;

   // Scan-round counter, bumped on the edge where idx wraps 3 -> 0.
   always_ff @(posedge Clk_O or negedge Reset) begin
      if (!Reset) begin
         r_rnd <= 6'd0;
      end else if (w_pre_wrap && (r_idx == 2'd3)) begin
         r_rnd <= r_rnd + 6'd1;
      end
   end

   assign w_dp_lit = (r_idx == 2'd1) && !r_rnd[5];
`else
   assign w_dp_lit = (r_idx == 2'd1);
`endif

   // Select the anode and nibble for the digit currently being scanned.
   always_comb begin
      w_an  = 4'b1111;
      w_nib = 4'h0;
      case (r_idx)
         2'd0: begin w_an = 4'b0111; w_nib = r_cap[15:12]; end
         2'd1: begin w_an = 4'b1011; w_nib = r_cap[11:8];  end
         2'd2: begin w_an = 4'b1101; w_nib = r_cap[7:4];   end
         2'd3: begin w_an = 4'b1110; w_nib = r_cap[3:0];   end
         default: begin w_an = 4'b1111; w_nib = 4'h0; end
      endcase
   end

   // Hex to active-low segments, bit order {g,f,e,d,c,b,a}.
   always_comb begin
      w_seg = 7'h7F;
      case (w_nib)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
         default: w_seg = 7'h7F;
      endcase
   end

   // Registered pin drivers; reset blanks the display immediately.
   always_ff @(posedge Clk_O or negedge Reset) begin
      if (!Reset) begin
         Seg <= 7'h7F;
         An  <= 4'hF;
         Dp  <= 1'b1;
      end else begin
         Seg <= w_seg;
         An  <= w_an;
         Dp  <= !w_dp_lit;
      end
   end

endmodule

// File: tb/tb_seg7_trace_scan.sv
// Bench for seg7_trace_scan with PRESCALE_W=2: a time-indexed reference
// model predicts each clock's display output and a monitor compares it.
module tb_seg7_trace_scan;

   localparam int P    = 2;
   localparam int DWELL = 1 << P;
   localparam int SCAN  = 4 * DWELL;

   logic       clk;
   logic       rst_n;
   logic [7:0] pc;
   logic [7:0] ins;
   logic       cap_i;
   logic       hold_i;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   seg7_trace_scan #(.PRESCALE_W(P)) dut (
      .Clk_O      (clk),
      .Reset      (rst_n),
      .PC         (pc),
      .Instruction(ins),
      .Capture    (cap_i),
      .Hold       (hold_i),
      .Seg        (seg),
      .Dp         (dp),
      .An         (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic       dp;
   } exp_t;

   exp_t q[$];

   logic [6:0] hexseg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] anmap [4]   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   int          errors = 0;
   int          checks = 0;
   int          n_edges;
   logic [15:0] m_cap;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Predict the output after the coming edge from the edge count and the
   // captured value, then apply this cycle's capture rule to the model.
   task automatic drive_push(input logic c, input logic h, input logic [7:0] p, input logic [7:0] i);
      int   idx;
      int   rounds;
      logic lit;
      exp_t e;
      cap_i  = c;
      hold_i = h;
      pc     = p;
      ins    = i;
      idx    = (n_edges / DWELL) % 4;
      rounds = (n_edges / SCAN) % 64;
`ifdef SEG7_DP_BLINK_EN
      lit = (idx == 1) && (rounds < 32);
`else
      lit = (idx == 1);
`endif
      e.seg = hexseg[(m_cap >> (4 * (3 - idx))) & 16'hF];
      e.an  = anmap[idx];
      e.dp  = !lit;
      q.push_back(e);
      if (c && !h) m_cap = {p, i};
      n_edges++;
   endtask

   task automatic cycle(input logic c, input logic h, input logic [7:0] p, input logic [7:0] i);
      @(negedge clk);
      drive_push(c, h, p, i);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, hold_i, pc, ins);
   endtask

   // Release reset on a falling edge and immediately queue the first edge.
   task automatic release_reset();
      @(negedge clk);
      rst_n   = 1'b1;
      n_edges = 0;
      m_cap   = 16'h0000;
      drive_push(1'b0, 1'b0, pc, ins);
   endtask

   // Monitor: every rising edge with a pending prediction gets compared.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("seg", int'(seg), int'(e.seg));
            check("an",  int'(an),  int'(e.an));
            check("dp",  int'(dp),  int'(e.dp));
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      pc     = 8'h00;
      ins    = 8'h00;
      cap_i  = 1'b0;
      hold_i = 1'b0;
      n_edges = 0;
      m_cap   = 16'h0000;

      repeat (10) @(posedge clk);
      #2;
      check("reset_seg", int'(seg), 'h7F);
      check("reset_an",  int'(an),  'hF);
      check("reset_dp",  int'(dp),  1);

      // Scan order with nothing captured.
      release_reset();
      idle(SCAN - 1);

      // Capture 3A/C5 and watch a full scan plus a bit.
      cycle(1'b1, 1'b0, 8'h3A, 8'hC5);
      idle(SCAN + 3);

      // Hold blocks a capture of FF.
      cycle(1'b0, 1'b1, 8'hFF, 8'hC5);
      cycle(1'b1, 1'b1, 8'hFF, 8'hC5);
      idle(SCAN);
      cycle(1'b0, 1'b0, 8'hFF, 8'hC5);
      cycle(1'b1, 1'b0, 8'hFF, 8'hC5);
      idle(SCAN);

      // Capture landing exactly on a prescaler wrap (edge count = DWELL-1 mod DWELL).
      while ((n_edges % DWELL) != DWELL - 1) cycle(1'b0, 1'b0, 8'h00, 8'h00);
      cycle(1'b1, 1'b0, 8'h9E, 8'h71);
      idle(SCAN);

      // Changing inputs without Capture has no effect.
      for (int k = 0; k < SCAN; k++)
         cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom));

      // Long random run; crosses scan rounds 32 and 64 for the blink variant.
      for (int k = 0; k < 70 * SCAN; k++)
         cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
               8'($urandom), 8'($urandom));

      // Let the monitor take the last prediction, then reset mid-dwell.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_seg", int'(seg), 'h7F);
      check("midreset_an",  int'(an),  'hF);
      check("midreset_dp",  int'(dp),  1);
      repeat (3) @(posedge clk);

      release_reset();
      for (int k = 0; k < 3 * SCAN; k++)
         cycle(($urandom_range(0, 3) == 0), 1'b0, 8'($urandom), 8'($urandom));

      // Bounded drain of outstanding predictions.
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      #2;
      check("drain_left", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_trace_scan.md
# seg7_trace_scan

Downstream display stage for the MIPS core: samples the fetch pair (PC, Instruction) seen by the core and shows it as four hex digits on a time-multiplexed, common-anode seven-segment display. The layout is PC high, PC low, instruction high, instruction low. It contains a refresh prescaler, a digit-scan counter, a capture register with a freeze control, and registered segment/anode drivers. It sits beside instruction memory on the PC/Instruction nets and drives the board display pins.

## Interface
- PRESCALE_W, 16 — prescaler width; the display advances one digit every 2^PRESCALE_W clocks.
- Clk_O  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PC  input  8  current fetch address from the core.
- Instruction  input  8  instruction word returned for PC.
- Capture  input  1  sample strobe; level-sensitive, sampled every clock.
- Hold  input  1  freeze; while 1, the captured value is not updated.
- Seg  output  7  segment cathodes, active-low; Seg[0]=a … Seg[6]=g.
- Dp  output  1  decimal-point cathode, active-low.
- An  output  4  digit anodes, active-low, one-hot-low; An[3] is the leftmost digit.

## Operation
- Capture register cap[15:0] = {PC, Instruction}.
  - Loads on any edge where Capture=1 and Hold=0.
  - Hold=1 overrides Capture.
- Prescaler pre[PRESCALE_W-1:0] increments every clock and wraps to 0.
- Digit index idx[1:0] increments (modulo 4) on each edge where pre is all-ones.
- Digit mapping:
  - idx 0 → An=4'b0111, nibble cap[15:12]
  - idx 1 → An=4'b1011, nibble cap[11:8]
  - idx 2 → An=4'b1101, nibble cap[7:4]
  - idx 3 → An=4'b1110, nibble cap[3:0]
- Hex decode (active-low, {g..a}): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Dp acts as the separator between PC and instruction:
  - Lit (0) only while idx=1.
  - Otherwise 1.
  - See Configuration for the blinking variant.
- No state machine beyond the counters. The scan is free-running and never stalls; Hold affects only cap.

## Timing
- All outputs are registered. Each edge computes them from the pre-edge values of idx and cap:
  - Seg(t+1) = decode(nibble(cap(t), idx(t)))
  - An(t+1) = map(idx(t))
- Capture latency: Capture=1 at edge k updates cap at k. If the matching digit is active at k+1, Seg shows the new value after edge k+1.
- Digit dwell is exactly 2^PRESCALE_W clocks. A full scan takes 4·2^PRESCALE_W clocks.
- Capture and Hold asserted on the same edge: cap is unchanged.
- Changing PC/Instruction while Capture=0: no effect on outputs.
- Reset asserted (Reset=0), asynchronously at any time:
  - pre=0, idx=0, cap=0.
  - Seg=7'h7F (blank), An=4'hF (all off), Dp=1.
  - Applies immediately, without waiting for a clock edge, including mid-dwell.
- First edge after Reset deasserts: An=4'b0111, Seg=7'h40 (digit "0").
- pre wrap on the same edge as a capture: idx advances and cap loads together. The new idx is used from the next edge onward.

## Configuration
- SEG7_DP_BLINK_EN
  - Defined:
    - An additional 6-bit scan-round counter increments each time idx wraps 3→0. It is cleared by reset.
    - The separator Dp on idx=1 is lit only while counter bit 5 is 0, giving a blink with a period of 64 full scans.
  - Not defined: the counter is absent and the Dp separator is lit on every idx=1 dwell.

## Test plan
- Reset: hold Reset=0 for 10 clocks -> Seg=7'h7F, An=4'hF, Dp=1. Assert Reset=0 mid-dwell -> the same values appear immediately, before the next edge.
- Scan order, PRESCALE_W=2:
  - Run 16 clocks after release -> An cycles 0111, 1011, 1101, 1110.
  - Each value lasts 4 clocks.
  - Seg=7'h40 throughout (cap=0).
- Capture, PRESCALE_W=2, PC=8'h3A, Instruction=8'hC5:
  - One Capture pulse.
  - Following scan -> Seg 7'h30, 7'h08, 7'h46, 7'h12 on An 0111, 1011, 1101, 1110 respectively.
  - Dp=0 only during An=1011.
- Hold priority:
  - After the capture above, set Hold=1, change PC=8'hFF, pulse Capture -> display still shows 3A/C5.
  - Release Hold, pulse Capture -> display shows FF/C5.
- Simultaneous events: Capture asserted on the edge where pre wraps -> cap and idx both update on that edge, and the next edge drives the new nibble for the new digit.
- SEG7_DP_BLINK_EN defined, PRESCALE_W=2 -> Dp stays at 1 during idx=1 for scan rounds 32–63, then resumes pulsing low.
